// File: rtl/debounce_pulse_if.sv
// debounce_pulse_if: the button-side bundle of the debouncer.
//   btn_in    : raw, asynchronous, bouncy button level (into the debouncer)
//   pulse_out : one-cycle count-enable pulse per accepted press
//   level_out : debounced button level, 1 = pressed
// master = whoever drives the button and consumes the outputs; slave = debouncer.
interface debounce_pulse_if;
    logic btn_in;
    logic pulse_out;
    logic level_out;

    modport master (output btn_in, input pulse_out, input level_out);
    modport slave  (input btn_in, output pulse_out, output level_out);
endinterface

// File: rtl/debounce_pulse.sv
// debounce_pulse: turns a raw pushbutton into one clean count-enable pulse
// per physical press. Pipeline: 2-flop synchronizer -> debounce FSM with a
// stability counter -> registered one-shot.
// Ports:
//   clk : system clock, all state on the rising edge
//   rst : synchronous active-high reset
//   bus : debounce_pulse_if.slave (btn_in in; pulse_out, level_out out)
module debounce_pulse #(
    parameter int   STABLE_CYCLES = 16,
    parameter int   CNT_WIDTH     = 5,
    parameter logic ACTIVE_LEVEL  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    debounce_pulse_if.slave   bus
);

    if (STABLE_CYCLES < 2 || STABLE_CYCLES > (1 << CNT_WIDTH) - 1) begin : g_bad_params
        $error("debounce_pulse: STABLE_CYCLES must be in 2..2^CNT_WIDTH-1");
    end

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    logic                 sync1_q, sync2_q;
    logic                 act;
    state_t               state_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 pulse_q;
    logic                 level_q;

    // Two-flop synchronizer; resets to the released level so a held button
    // looks like a fresh press once reset drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= ~ACTIVE_LEVEL;
            sync2_q <= ~ACTIVE_LEVEL;
        end else begin
            sync1_q <= bus.btn_in;
            sync2_q <= sync1_q;
        end
    end

    assign act = (sync2_q == ACTIVE_LEVEL);

    // Debounce FSM. level_q tracks the next state (PRESSED/RELEASE_WAIT) so
    // it lines up with state_q; pulse_q is set only on PRESS_WAIT->PRESSED.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            level_q <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    level_q <= 1'b0;
                    if (act) begin
                        state_q <= PRESS_WAIT;
                        cnt_q   <= CNT_ONE;
                    end else begin
                        cnt_q   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!act) begin
                        // Glitch: level did not hold long enough.
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        level_q <= 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= PRESSED;
                        cnt_q   <= '0;
                        pulse_q <= 1'b1;
                        level_q <= 1'b1;
                    end else begin
                        cnt_q   <= cnt_q + CNT_ONE;
                        level_q <= 1'b0;
                    end
                end
                PRESSED: begin
                    level_q <= 1'b1;
                    if (!act) begin
                        state_q <= RELEASE_WAIT;
                        cnt_q   <= CNT_ONE;
                    end
                end
                RELEASE_WAIT: begin
                    if (act) begin
                        // Release bounce: fall back without a new pulse.
                        state_q <= PRESSED;
                        cnt_q   <= '0;
                        level_q <= 1'b1;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        level_q <= 1'b0;
                    end else begin
                        cnt_q   <= cnt_q + CNT_ONE;
                        level_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    level_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pulse_out = pulse_q;
    assign bus.level_out = level_q;

endmodule

// File: doc/debounce_pulse.md
Name: debounce_pulse

Overview:
Conditions a raw mechanical pushbutton input into one clean, single-cycle count-enable pulse per press. Feeds the count-enable input of the 4-bit wrap-around counter stage directly downstream, so each physical press advances the count by exactly one.
- Stages: 2-flop synchronizer, then debounce FSM with stability counter, then registered one-shot pulse.

Parameters:
STABLE_CYCLES, 16, consecutive synchronized samples required to accept a level change; legal range 2..2^CNT_WIDTH-1.
CNT_WIDTH, 5, width of the stability counter; must hold STABLE_CYCLES-1.
ACTIVE_LEVEL, 1, value of btn_in meaning "pressed".

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  reset; synchronous, active-high.
btn_in  input  1  raw asynchronous, bouncy button level.
pulse_out  output  1  registered one-cycle pulse per accepted press; drives downstream count enable.
level_out  output  1  registered debounced button level (1 = pressed).

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high: rst=1 sampled at a clk rising edge clears all state.
- Reset values:
  - Both sync flops = ~ACTIVE_LEVEL.
  - State = IDLE, counter = 0.
  - pulse_out = 0, level_out = 0.
  - Reset overrides every other transition, including mid-PRESS_WAIT and mid-PRESSED. No pulse is emitted on reset entry or exit.
- Synchronizer: btn_sync = btn_in delayed by 2 flops. act = (btn_sync == ACTIVE_LEVEL). The FSM uses only act.
- IDLE (level_out=0):
  - act=1: go to PRESS_WAIT, counter=1.
  - Otherwise: stay, counter=0.
- PRESS_WAIT (level_out=0):
  - act=0: go to IDLE, counter=0 (glitch rejected).
  - act=1 and counter==STABLE_CYCLES-1: go to PRESSED, counter=0, pulse_out<=1.
  - Else: counter+1.
- PRESSED (level_out=1):
  - act=0: go to RELEASE_WAIT, counter=1.
  - Otherwise: stay.
- RELEASE_WAIT (level_out=1):
  - act=1: go back to PRESSED, counter=0. No new pulse; release bounce is absorbed.
  - act=0 and counter==STABLE_CYCLES-1: go to IDLE, counter=0.
  - Else: counter+1.
- pulse_out:
  - High for exactly one cycle: the first cycle in PRESSED entered from PRESS_WAIT. Zero in every other cycle.
  - Never two pulses without an intervening return to IDLE.
- level_out: registered; 1 exactly when the registered state is PRESSED or RELEASE_WAIT.
- Latency: edge 1 is the first rising edge that samples btn_in at the active level, with btn_in held stable from then on.
  - pulse_out and level_out rise after edge STABLE_CYCLES+2 (edge 18 at default).
  - Release is symmetric: level_out falls after edge STABLE_CYCLES+2 counted from the first inactive sample.
- Counter:
  - Unsigned, never exceeds STABLE_CYCLES-1, no wrap.
  - Compare is equality against STABLE_CYCLES-1, truncated to CNT_WIDTH.
- Held through reset: if btn_in stays active across rst deassertion, the block treats it as a new press and emits one pulse STABLE_CYCLES+2 edges after the first post-reset sample.
- Minimum press-to-press spacing: 2*(STABLE_CYCLES+2) cycles. Faster toggling yields fewer pulses, never extra ones.
- Illegal or unused state encodings recover to IDLE on the next edge.

Test Plan:
1. Reset: rst=1 for 3 edges with btn_in toggling -> pulse_out=0 and level_out=0 throughout and on the first edge after rst=0.
2. Clean press, default params: btn_in active from edge 1, held 40 cycles, then inactive -> pulse_out=1 only in the cycle after edge 18; level_out=1 from edge 18 until 18 edges after release; exactly one pulse total.
3. Bounce then settle: btn_in toggles every 3 cycles for 30 cycles, then held active -> no pulse during bounce; exactly one pulse 18 edges after the last rising transition.
4. Glitch rejection: active for 15 cycles, then inactive 40 -> no pulse, level_out stays 0. Repeat with 16 cycles -> exactly one pulse.
5. Release bounce: in PRESSED, btn_in inactive 10 cycles, then active 20, then inactive 40 -> level_out stays 1 through the 10-cycle dip; no second pulse; single falling edge on level_out.
6. Reset mid-operation with downstream counter attached:
   - Assert rst during PRESS_WAIT -> no pulse.
   - Assert rst during PRESSED while held -> exactly one new pulse 18 edges after rst deasserts.
   - Then 5 clean presses -> counter reads 5 (plus 1 for the held-through-reset press); 16 presses from 0 -> counter wraps to 0.
